// File: rtl/tx_scrambler.sv
// tx_scrambler
//
// Per-lane PCIe transmit scrambler between the lane-striping/ordered-set
// logic and the PIPE TX interface. Data symbols are scrambled with the
// Gen1/2 16-bit LFSR or the Gen3 23-bit LFSR. K symbols and bypassed symbols
// go through unscrambled. The LFSR stepping and reset rules match the
// receive-side lane descrambler, so a looped-back lane reproduces its bytes.
//
// Configuration macro: TX_SCRAMBLER_GEN3_EN
//   defined   - Gen3 LFSR, reseed and sync-header rules are built.
//   undefined - Gen3 logic is removed; for GEN >= 3 the data is passed
//               through unscrambled and reseed/seedValue are ignored.
//
// Parameters
//   GEN3_DEFAULT_SEED  power-up Gen3 LFSR value (bits [22:0] used)
//
// Ports
//   clk           lane clock
//   reset         synchronous, active-high reset
//   GEN           link generation: 1/2 = 8b/10b, 3 = 128b/130b
//   PIPEWIDTH     8/16/32 -> 1/2/4 symbols per beat; other values act as 8
//   turnOff       scrambling disabled, LFSR still steps
//   inValid       input beat valid
//   inData        symbols, [7:0] first in time
//   inDataK       per-symbol K flag (Gen1/2 only)
//   inBypass      per-symbol: send unscrambled, LFSR still steps
//   inSyncHeader  Gen3 block type: 2'b10 data, 2'b01 ordered set
//   inStartBlock  Gen3 first beat of a block
//   reseed        Gen3: load LFSR from seedValue before this beat
//   seedValue     Gen3 per-lane seed, bits [22:0] used
//   TxData        scrambled symbols, unused bytes 0
//   TxDataK       registered inDataK
//   TxDataValid   registered inValid
//   TxSyncHeader  registered inSyncHeader
//   TxStartBlock  registered inStartBlock

module tx_scrambler #(
    parameter logic [23:0] GEN3_DEFAULT_SEED = 24'h1dbfbc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  GEN,
    input  logic [5:0]  PIPEWIDTH,
    input  logic        turnOff,
    input  logic        inValid,
    input  logic [31:0] inData,
    input  logic [3:0]  inDataK,
    input  logic [3:0]  inBypass,
    input  logic [1:0]  inSyncHeader,
    input  logic        inStartBlock,
    input  logic        reseed,
    input  logic [23:0] seedValue,
    output logic [31:0] TxData,
    output logic [3:0]  TxDataK,
    output logic        TxDataValid,
    output logic [1:0]  TxSyncHeader,
    output logic        TxStartBlock
);

    localparam logic [7:0]  SYM_COM     = 8'hBC;
    localparam logic [7:0]  SYM_SKP     = 8'h1C;
    localparam logic [15:0] GEN12_SEED  = 16'hFFFF;
    localparam logic [15:0] GEN12_TAPS  = 16'h0039;
    localparam logic [1:0]  SH_DATA     = 2'b10;

    // Keystream byte for the Gen1/2 LFSR: bit i is s[15] at step i (LSB first).
    function automatic logic [7:0] gen12Mask(input logic [15:0] s);
        logic [15:0] t;
        logic [7:0]  m;
        t = s;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = t[15];
            t    = {t[14:0], 1'b0} ^ (t[15] ? GEN12_TAPS : 16'h0000);
        end
        return m;
    endfunction

    function automatic logic [15:0] gen12Advance(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[14:0], 1'b0} ^ (t[15] ? GEN12_TAPS : 16'h0000);
        end
        return t;
    endfunction

`ifdef TX_SCRAMBLER_GEN3_EN
    localparam logic [22:0] GEN3_TAPS = 23'h210125;

    function automatic logic [7:0] gen3Mask(input logic [22:0] s);
        logic [22:0] t;
        logic [7:0]  m;
        t = s;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = t[22];
            t    = {t[21:0], 1'b0} ^ (t[22] ? GEN3_TAPS : 23'h000000);
        end
        return m;
    endfunction

    function automatic logic [22:0] gen3Advance(input logic [22:0] s);
        logic [22:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[21:0], 1'b0} ^ (t[22] ? GEN3_TAPS : 23'h000000);
        end
        return t;
    endfunction

    logic [22:0] gen3Lfsr;
    logic [22:0] gen3Work;

    // The top seed bit is not part of the 23-bit LFSR.
    logic unusedBits;
    assign unusedBits = seedValue[23] ^ GEN3_DEFAULT_SEED[23];
`else
    // Without Gen3 support the reseed interface has no function.
    logic unusedBits;
    assign unusedBits = ^{reseed, seedValue, GEN3_DEFAULT_SEED};
`endif

    logic [15:0] gen12Lfsr;
    logic [15:0] gen12Work;
    logic [31:0] dataNext;
    logic [3:0]  laneEn;
    logic [7:0]  curSym;
    logic        isGen3;
    logic        plainSym;

    assign isGen3 = (GEN >= 3'd3);

    always_comb begin
        case (PIPEWIDTH)
            6'd16:   laneEn = 4'b0011;
            6'd32:   laneEn = 4'b1111;
            default: laneEn = 4'b0001;
        endcase
    end

    // Symbols are handled strictly in time order so that a COM resets the
    // LFSR for the symbols that follow it inside the same beat.
    always_comb begin
        gen12Work = gen12Lfsr;
        dataNext  = '0;
        curSym    = '0;
        plainSym  = 1'b0;
`ifdef TX_SCRAMBLER_GEN3_EN
        gen3Work  = (inValid && isGen3 && reseed) ? seedValue[22:0] : gen3Lfsr;
`endif
        for (int n = 0; n < 4; n++) begin
            if (laneEn[n]) begin
                curSym   = inData[n*8 +: 8];
                plainSym = turnOff || inBypass[n];
                if (isGen3) begin
`ifdef TX_SCRAMBLER_GEN3_EN
                    if (inSyncHeader == SH_DATA) begin
                        dataNext[n*8 +: 8] = plainSym ? curSym
                                                      : (curSym ^ gen3Mask(gen3Work));
                        gen3Work = gen3Advance(gen3Work);
                    end else begin
                        // Ordered-set block: unscrambled, LFSR frozen.
                        dataNext[n*8 +: 8] = curSym;
                    end
`else
                    dataNext[n*8 +: 8] = curSym;
`endif
                end else if (inDataK[n]) begin
                    dataNext[n*8 +: 8] = curSym;
                    if (curSym == SYM_COM) begin
                        gen12Work = GEN12_SEED;
                    end else if (curSym != SYM_SKP) begin
                        gen12Work = gen12Advance(gen12Work);
                    end
                end else begin
                    dataNext[n*8 +: 8] = plainSym ? curSym
                                                  : (curSym ^ gen12Mask(gen12Work));
                    gen12Work = gen12Advance(gen12Work);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            TxData       <= '0;
            TxDataK      <= '0;
            TxDataValid  <= 1'b0;
            TxSyncHeader <= '0;
            TxStartBlock <= 1'b0;
            gen12Lfsr    <= GEN12_SEED;
`ifdef TX_SCRAMBLER_GEN3_EN
            gen3Lfsr     <= GEN3_DEFAULT_SEED[22:0];
`endif
        end else if (inValid) begin
            TxData       <= dataNext;
            TxDataK      <= inDataK;
            TxDataValid  <= 1'b1;
            TxSyncHeader <= inSyncHeader;
            TxStartBlock <= inStartBlock;
            // Only the LFSR of the active generation moves.
            if (isGen3) begin
`ifdef TX_SCRAMBLER_GEN3_EN
                gen3Lfsr <= gen3Work;
`endif
            end else begin
                gen12Lfsr <= gen12Work;
            end
        end else begin
            TxData       <= '0;
            TxDataK      <= '0;
            TxDataValid  <= 1'b0;
            TxSyncHeader <= '0;
            TxStartBlock <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_scrambler.sv
module tb_tx_scrambler;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  GEN;
    logic [5:0]  PIPEWIDTH;
    logic        turnOff;
    logic        inValid;
    logic [31:0] inData;
    logic [3:0]  inDataK;
    logic [3:0]  inBypass;
    logic [1:0]  inSyncHeader;
    logic        inStartBlock;
    logic        reseed;
    logic [23:0] seedValue;
    logic [31:0] TxData;
    logic [3:0]  TxDataK;
    logic        TxDataValid;
    logic [1:0]  TxSyncHeader;
    logic        TxStartBlock;

    tx_scrambler dut (
        .clk(clk), .reset(reset), .GEN(GEN), .PIPEWIDTH(PIPEWIDTH),
        .turnOff(turnOff), .inValid(inValid), .inData(inData),
        .inDataK(inDataK), .inBypass(inBypass), .inSyncHeader(inSyncHeader),
        .inStartBlock(inStartBlock), .reseed(reseed), .seedValue(seedValue),
        .TxData(TxData), .TxDataK(TxDataK), .TxDataValid(TxDataValid),
        .TxSyncHeader(TxSyncHeader), .TxStartBlock(TxStartBlock)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: the two scramblers as bit-serial shift registers.
    logic [15:0] mG12;
    logic [22:0] mG3;

    logic [31:0] expData;
    logic [3:0]  expK;
    logic        expValid;
    logic [1:0]  expSh;
    logic        expSb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One byte through the Gen1/2 scrambler, one bit at a time, LSB first.
    task automatic refByte12(input logic [7:0] d, input logic scr, output logic [7:0] o);
        for (int i = 0; i < 8; i++) begin
            o[i] = d[i] ^ (scr & mG12[15]);
            mG12 = {mG12[14:0], 1'b0} ^ (mG12[15] ? 16'h0039 : 16'h0000);
        end
    endtask

    task automatic refByte3(input logic [7:0] d, input logic scr, output logic [7:0] o);
        for (int i = 0; i < 8; i++) begin
            o[i] = d[i] ^ (scr & mG3[22]);
            mG3  = {mG3[21:0], 1'b0} ^ (mG3[22] ? 23'h210125 : 23'h000000);
        end
    endtask

    task automatic refBeat(input logic rst, input logic [2:0] gen, input logic [5:0] pw,
                           input logic val, input logic [31:0] data, input logic [3:0] k,
                           input logic [3:0] byp, input logic toff, input logic [1:0] sh,
                           input logic sb, input logic rs, input logic [23:0] seed);
        int nsym;
        logic [7:0] b;
        logic [7:0] o;
        nsym = (pw == 6'd16) ? 2 : (pw == 6'd32) ? 4 : 1;
        expData = '0; expK = '0; expValid = 1'b0; expSh = '0; expSb = 1'b0;
        if (rst) begin
            mG12 = 16'hFFFF;
            mG3  = 23'h1dbfbc;
        end else if (val) begin
            expK = k; expValid = 1'b1; expSh = sh; expSb = sb;
            for (int n = 0; n < nsym; n++) begin
                b = data[8*n +: 8];
                o = b;
                if (gen >= 3'd3) begin
`ifdef TX_SCRAMBLER_GEN3_EN
                    if (n == 0 && rs) mG3 = seed[22:0];
                    if (sh == 2'b10) refByte3(b, !(toff || byp[n]), o);
`endif
                end else if (k[n] && b == 8'hBC) begin
                    mG12 = 16'hFFFF;
                end else if (k[n] && b == 8'h1C) begin
                    o = b;
                end else if (k[n]) begin
                    refByte12(b, 1'b0, o);
                end else begin
                    refByte12(b, !(toff || byp[n]), o);
                end
                expData[8*n +: 8] = o;
            end
        end
    endtask

    task automatic beat(input string tag, input logic rst, input logic [2:0] gen,
                        input logic [5:0] pw, input logic val, input logic [31:0] data,
                        input logic [3:0] k, input logic [3:0] byp, input logic toff,
                        input logic [1:0] sh, input logic sb, input logic rs,
                        input logic [23:0] seed);
        reset = rst; GEN = gen; PIPEWIDTH = pw; inValid = val; inData = data;
        inDataK = k; inBypass = byp; turnOff = toff; inSyncHeader = sh;
        inStartBlock = sb; reseed = rs; seedValue = seed;
        refBeat(rst, gen, pw, val, data, k, byp, toff, sh, sb, rs, seed);
        @(posedge clk);
        #1;
        check({tag, ".data"},  TxData,               expData);
        check({tag, ".k"},     {28'd0, TxDataK},     {28'd0, expK});
        check({tag, ".valid"}, {31'd0, TxDataValid}, {31'd0, expValid});
        check({tag, ".sh"},    {30'd0, TxSyncHeader}, {30'd0, expSh});
        check({tag, ".sb"},    {31'd0, TxStartBlock}, {31'd0, expSb});
    endtask

    task automatic g12(input string tag, input logic [5:0] pw, input logic [31:0] data,
                       input logic [3:0] k, input logic toff, input logic [3:0] byp);
        beat(tag, 1'b0, 3'd1, pw, 1'b1, data, k, byp, toff, 2'b00, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic g3(input string tag, input logic [31:0] data, input logic [1:0] sh,
                      input logic sb, input logic rs, input logic [23:0] seed);
        beat(tag, 1'b0, 3'd3, 6'd32, 1'b1, data, 4'h0, 4'h0, 1'b0, sh, sb, rs, seed);
    endtask

    logic [31:0] rData;
    logic [3:0]  rK;
    logic [5:0]  rPw;
    logic [2:0]  rGen;
    int          sel;

    initial begin
        mG12 = 16'hFFFF;
        mG3  = 23'h1dbfbc;

        beat("rst0", 1'b1, 3'd1, 6'd8, 1'b1, 32'hDEADBEEF, 4'hF, 4'h0, 1'b0, 2'b10, 1'b1, 1'b0, 24'h0);
        beat("rst1", 1'b1, 3'd1, 6'd8, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 24'h0);
        check("rst_state", TxData, 32'h0);

        g12("com8", 6'd8, 32'h000000BC, 4'h1, 1'b0, 4'h0);
        check("tp_com", TxData, 32'h000000BC);
        g12("d0a", 6'd8, 32'h0, 4'h0, 1'b0, 4'h0);
        check("tp_ff", TxData, 32'h000000FF);
        g12("d0b", 6'd8, 32'h0, 4'h0, 1'b0, 4'h0);
        check("tp_17", TxData, 32'h00000017);

        g12("w32a", 6'd32, 32'hBC000000, 4'h8, 1'b0, 4'h0);
        g12("w32skp", 6'd32, 32'h001C0000, 4'h4, 1'b0, 4'h0);
        check("tp_skp_hold", TxData, 32'hC01C17FF);

        g12("toffCom", 6'd8, 32'h000000BC, 4'h1, 1'b0, 4'h0);
        g12("toff1", 6'd8, 32'h000000A5, 4'h0, 1'b1, 4'h0);
        check("tp_toff", TxData, 32'h000000A5);
        g12("toff2", 6'd8, 32'h000000A5, 4'h0, 1'b1, 4'h0);
        g12("toffEnd", 6'd8, 32'h000000A5, 4'h0, 1'b0, 4'h0);
        check("tp_toff_resume", TxData, 32'h00000065);

        g12("bcDataCom", 6'd8, 32'h000000BC, 4'h1, 1'b0, 4'h0);
        g12("bcData", 6'd8, 32'h000000BC, 4'h0, 1'b0, 4'h0);
        check("bc_as_data", TxData, 32'h00000043);

        g12("byp", 6'd32, 32'h5A5A5A5A, 4'h0, 1'b0, 4'b0101);
        g12("multiCom", 6'd32, 32'h00BC00BC, 4'b0101, 1'b0, 4'h0);
        check("multi_com", TxData, 32'hFFBCFFBC);
        g12("pw16", 6'd16, 32'hAAAA00BC, 4'h1, 1'b0, 4'h0);
        check("pw16_mask", TxData, 32'h0000FFBC);
        beat("idle", 1'b0, 3'd1, 6'd8, 1'b0, 32'h12345678, 4'hF, 4'h0, 1'b0, 2'b10, 1'b1, 1'b0, 24'h0);
        check("idle_zero", TxData, 32'h0);
        g12("afterIdle", 6'd8, 32'h0, 4'h0, 1'b0, 4'h0);
        check("idle_hold", TxData, 32'h00000017);

        g3("g3os", 32'h12345678, 2'b01, 1'b1, 1'b0, 24'h0);
        check("g3_passthru", TxData, 32'h12345678);
`ifdef TX_SCRAMBLER_GEN3_EN
        g3("g3seed", 32'h0, 2'b10, 1'b1, 1'b1, 24'h1dbfbc);
        g3("g3d1", 32'h0, 2'b10, 1'b0, 1'b0, 24'h0);
        g3("g3d2", 32'h0, 2'b10, 1'b0, 1'b0, 24'h0);
        g3("g3os1", 32'hCAFEF00D, 2'b01, 1'b1, 1'b0, 24'h0);
        check("g3_os_unmod", TxData, 32'hCAFEF00D);
        g3("g3os2", 32'h0BADBEEF, 2'b01, 1'b0, 1'b0, 24'h0);
        g3("g3d3", 32'h0, 2'b10, 1'b1, 1'b0, 24'h0);
        g3("g3reseedMid", 32'h0, 2'b10, 1'b0, 1'b1, 24'h0A5A5A);
`endif
        g12("g12held", 6'd8, 32'h0, 4'h0, 1'b0, 4'h0);
        check("g12_held_over_g3", TxData, 32'h000000C0);

        g12("s16a", 6'd16, 32'h00001234, 4'h0, 1'b0, 4'h0);
        beat("midRst", 1'b1, 3'd1, 6'd16, 1'b1, 32'h00005678, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 24'h0);
        check("mid_rst_zero", TxData, 32'h0);
        g12("postRst", 6'd16, 32'h000000BC, 4'h1, 1'b0, 4'h0);
        check("post_rst_com", TxData, 32'h0000FFBC);

        for (int i = 0; i < 400; i++) begin
            rData = '0;
            rK    = '0;
            for (int n = 0; n < 4; n++) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0:       begin rData[8*n +: 8] = 8'hBC; rK[n] = 1'b1; end
                    1:       begin rData[8*n +: 8] = 8'h1C; rK[n] = 1'b1; end
                    2:       begin rData[8*n +: 8] = 8'($urandom); rK[n] = 1'b1; end
                    3:       rData[8*n +: 8] = 8'hBC;
                    default: rData[8*n +: 8] = 8'($urandom);
                endcase
            end
            case ($urandom_range(0, 3))
                0:       rPw = 6'd8;
                1:       rPw = 6'd16;
                2:       rPw = 6'd32;
                default: rPw = 6'($urandom_range(0, 63));
            endcase
            rGen = 3'($urandom_range(1, 3));
            beat("rand",
                 ($urandom_range(0, 49) == 0),
                 rGen, rPw,
                 ($urandom_range(0, 4) != 0),
                 rData, rK,
                 4'($urandom),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b10,
                 1'($urandom),
                 (rGen == 3'd3) && ($urandom_range(0, 9) == 0),
                 24'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
